// File: rtl/banked_mem_responder_pkg.sv
// banked_mem_responder_pkg: shared widths, bank geometry and timing defaults
package banked_mem_responder_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int NUM_BANKS = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH_LOG2_DEF = 15;
  localparam int BANK_BUSY_DEF = 4;
  localparam int RD_LAT_DEF = 2;
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_SEL_LSB +: BANK_W];
  endfunction
endpackage

// File: rtl/banked_mem_responder_if.sv
// banked_mem_responder_if: request/response bus between cache controller and memory
interface banked_mem_responder_if;
  import banked_mem_responder_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic wr;
  logic rd;
  logic stall;
  logic rd_valid;
  logic err;
  logic [NUM_BANKS-1:0] busy;
  modport master(output addr, data_in, wr, rd, input stall, busy, data_out, rd_valid, err);
  modport slave(input addr, data_in, wr, rd, output stall, busy, data_out, rd_valid, err);
endinterface

// File: rtl/banked_mem_responder_timer.sv
// mem_bank_timer: per-bank occupancy counter, loads on accept and saturates at zero
module mem_bank_timer #(
  parameter int BANK_BUSY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic busy_o
);
  localparam int CW = BANK_BUSY > 2 ? $clog2(BANK_BUSY) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign busy_o = cnt_q != '0;
  always_comb cnt_d = load_i ? CW'(BANK_BUSY - 1) : cnt_q - CW'(busy_o);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-way word-interleaved memory with bank stalls and fixed read latency
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int BANK_BUSY = BANK_BUSY_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic clk,
  input logic rst_n,
  banked_mem_responder_if.slave bus
);
  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;
  logic [NUM_BANKS-1:0] load, busy;
  logic [BANK_W-1:0] bank;
  logic [DEPTH_LOG2-1:0] idx;
  logic req, bad, acc, err_q, err_d;
  always_comb begin
    bank = bank_of(bus.addr);
    idx = bus.addr[DEPTH_LOG2:1];
    req = bus.rd | bus.wr;
    bad = (bus.rd & bus.wr) | (req & bus.addr[0]);
    acc = req & ~bad & ~busy[bank];
    load = acc ? NUM_BANKS'(1) << bank : '0;
    err_d = err_q | bad;
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank_timer #(.BANK_BUSY(BANK_BUSY)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .load_i(load[b]),
      .busy_o(busy[b])
    );
  end
  // Storage is deliberately outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk)
    if (acc & bus.wr) mem_q[idx] <= bus.data_in;
  // Idle stages carry zero so data_out is 0 whenever rd_valid is low.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= acc & bus.rd;
      dat_q[0] <= acc & bus.rd ? mem_q[idx] : '0;
      err_q <= err_d;
    end
  assign bus.stall = req & busy[bank];
  assign bus.busy = busy;
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.data_out = dat_q[RD_LAT-1];
  assign bus.err = err_q;
endmodule
